// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Loader FSM encodings and the width of the stream's word-count header.
package instr_mem_loader_pkg;

  localparam int LDR_LEN_W = 16;

  typedef enum logic [2:0] {
    LDR_ST_LEN_HI = 3'd0,
    LDR_ST_LEN_LO = 3'd1,
    LDR_ST_DATA   = 3'd2,
    LDR_ST_DONE   = 3'd3,
    LDR_ST_ERR    = 3'd4
  } ldr_state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Fetch port plus host byte link.
// The master side is the controller/host; the slave side is the loader.
interface instr_mem_loader_if;
  logic [15:0] memaddr;
  logic [31:0] memdata;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        load_req;

  modport master (
    output memaddr, ld_valid, ld_data, load_req,
    input  memdata, ld_ready
  );

  modport slave (
    input  memaddr, ld_valid, ld_data, load_req,
    output memdata, ld_ready
  );
endinterface

// File: rtl/instr_mem_loader_word_packer.sv
// 8->32 MSB-first byte assembler.
// out_valid/out_word are combinational on the 4th byte so the word lands on that same edge.
module word_packer (
  input  logic        clk,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        out_valid,
  output logic [31:0] out_word
);
  logic [1:0]  idx;
  logic [23:0] acc;

  always_ff @(posedge clk) begin
    if (clear) begin
      idx <= '0;
      acc <= '0;
    end else if (in_valid) begin
      idx <= idx + 2'd1;
      acc <= {acc[15:0], in_byte};
    end
  end

  assign out_valid = in_valid && (idx == 2'd3);
  assign out_word  = {acc, in_byte};
endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with combinational fetch port and a byte-stream program loader
// that holds the controller in reset until the declared number of words has arrived.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_mem_loader_if.slave    bus,
  output logic                 cpu_reset,
  output logic                 load_done,
  output logic                 load_err,
  output logic [LDR_LEN_W-1:0] words_loaded
);
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  ldr_state_t           state, state_nxt;
  logic [LDR_LEN_W-1:0] len, hdr_len;
  logic [ADDR_W-1:0]    wptr;
  logic                 accept, pk_valid, mem_we;
  logic [31:0]          pk_word;
  logic [31:0]          mem [DEPTH];

  // load_req steals the cycle: a byte presented alongside it is dropped
  assign accept  = bus.ld_valid && bus.ld_ready && !bus.load_req;
  assign hdr_len = {len[15:8], bus.ld_data};
  assign mem_we  = pk_valid && !reset;

  word_packer u_packer (
    .clk       (clk),
    .clear     (reset || bus.load_req),
    .in_valid  (accept && (state == LDR_ST_DATA)),
    .in_byte   (bus.ld_data),
    .out_valid (pk_valid),
    .out_word  (pk_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LDR_ST_LEN_HI;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.load_req) begin
      state_nxt = LDR_ST_LEN_HI;
    end else if (accept) begin
      case (state)
        LDR_ST_LEN_HI: state_nxt = LDR_ST_LEN_LO;
        LDR_ST_LEN_LO: begin
          if (hdr_len == '0)                state_nxt = LDR_ST_DONE;
          else if (32'(hdr_len) > DEPTH_W)  state_nxt = LDR_ST_ERR;
          else                              state_nxt = LDR_ST_DATA;
        end
        LDR_ST_DATA:
          if (pk_valid && (words_loaded + 16'd1 == len)) state_nxt = LDR_ST_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Flags decode straight from the state register, so they appear the cycle after entry
  always_comb begin
    bus.ld_ready = (state == LDR_ST_LEN_HI) || (state == LDR_ST_LEN_LO) ||
                   (state == LDR_ST_DATA);
    load_done    = (state == LDR_ST_DONE);
    load_err     = (state == LDR_ST_ERR);
    cpu_reset    = (state != LDR_ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset || bus.load_req) begin
      len          <= '0;
      wptr         <= '0;
      words_loaded <= '0;
    end else if (accept) begin
      if (state == LDR_ST_LEN_HI) len[15:8] <= bus.ld_data;
      if (state == LDR_ST_LEN_LO) len[7:0]  <= bus.ld_data;
      if (pk_valid) begin
        wptr         <= wptr + 1'b1;
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

  // Contents survive reset and reloads; only written words change
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr] <= pk_word;
  end

  assign bus.memdata = (32'(bus.memaddr) < DEPTH_W) ? mem[bus.memaddr[ADDR_W-1:0]] : 32'h0;
endmodule
